// File: rtl/mux_pipe_pkg.sv
// Shared definitions for mux_pipe: flag macros, FSM state encodings, MODE constants
// and the select-width helper used by the top and the selection sub-module.
// No ports; imported with "import mux_pipe_pkg::*;".
`ifndef MUX_PIPE_DEFINES
`define MUX_PIPE_DEFINES
`define True_v  1'b1
`define False_v 1'b0
`endif

package mux_pipe_pkg;

    // Buffer occupancy: nothing held, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int MODE_BINARY   = 0;  // in_sel picks the input
    localparam int MODE_PRIORITY = 1;  // lowest set bit of in_en picks the input

    // Select width is never allowed to collapse to zero bits.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_pipe_sel.sv
// Purpose: combinational input selection plus error flag for mux_pipe.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller samples the result only on an accepted beat.
// Ports: in_data (NUM_IN packed lanes), in_sel (MODE_BINARY), in_en (MODE_PRIORITY)
//        -> sel_data, sel_src, sel_err. sel_data/sel_src are zero whenever sel_err=1.
module mux_pipe_sel
    import mux_pipe_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int NUM_IN = 4,
    parameter  int MODE   = MODE_BINARY,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [NUM_IN-1:0]        in_en,
    output logic [DATA_W-1:0]        sel_data,
    output logic [SEL_W-1:0]         sel_src,
    output logic                     sel_err
);

    always_comb begin
        sel_data = '0;
        sel_src  = '0;
        sel_err  = `True_v;
        if (MODE == MODE_PRIORITY) begin
            // Scan from the top down so the lowest enabled index is written last and wins.
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (in_en[i] == `True_v) begin
                    sel_err  = `False_v;
                    sel_src  = SEL_W'(i);
                    sel_data = in_data[i*DATA_W +: DATA_W];
                end
            end
        end else begin
            // Matching against each legal index leaves sel_err set for out-of-range selects.
            for (int i = 0; i < NUM_IN; i++) begin
                if (in_sel == SEL_W'(i)) begin
                    sel_err  = `False_v;
                    sel_src  = SEL_W'(i);
                    sel_data = in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/mux_pipe.sv
// Purpose: N-to-1 mux with a two-entry (main + skid) output buffer and valid/ready handshakes.
// Latency: 1 cycle from acceptance into an empty buffer to out_valid.
// Backpressure: registered in_ready drops only when both entries are full; full throughput otherwise.
// Ports: clk, rst (async active-low); in_valid/in_ready/in_data/in_sel/in_en upstream;
//        out_valid/out_ready/out_data/out_src/out_err downstream.
module mux_pipe
    import mux_pipe_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int NUM_IN = 4,
    parameter  int MODE   = MODE_BINARY,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [NUM_IN-1:0]        in_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_src,
    output logic                     out_err
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  src;
        logic              err;
    } beat_t;

    state_e state_q, state_d;
    beat_t  main_q, main_d;
    beat_t  skid_q, skid_d;
    beat_t  new_beat;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   drain;

    // The selection result is captured at acceptance, so later input changes
    // never disturb a buffered beat.
    mux_pipe_sel #(
        .DATA_W (DATA_W),
        .NUM_IN (NUM_IN),
        .MODE   (MODE)
    ) u_sel (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_en    (in_en),
        .sel_data (new_beat.data),
        .sel_src  (new_beat.src),
        .sel_err  (new_beat.err)
    );

    assign accept = (in_valid == `True_v) && (in_ready_q == `True_v);
    assign drain  = (state_q != EMPTY) && (out_ready == `True_v);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = new_beat;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_d = new_beat;
                end else if (accept) begin
                    skid_d  = new_beat;
                    state_d = TWO;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Registered ready: low exactly when the skid entry will be occupied.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= `False_v;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q.data;
    assign out_src   = main_q.src;
    assign out_err   = main_q.err;

endmodule

// File: tb/tb_mux_pipe.sv
// Purpose: self-checking bench for mux_pipe (binary N=4, binary N=3, priority N=4, DATA_W=8).
// Latency: directed vectors with hand-computed values, then a random valid/ready run.
// Backpressure: out_ready is driven low/random to exercise skid and stall behaviour.
module tb_mux_pipe;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] src;
        logic       err;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  in_en;

    logic       rdy0, vld0, err0;
    logic [7:0] data0;
    logic [1:0] src0;
    logic       rdy1, vld1, err1;
    logic [7:0] data1;
    logic [1:0] src1;
    logic       rdy3, vld3, err3;
    logic [7:0] data3;
    logic [1:0] src3;

    int tests_run = 0;
    int tests_failed = 0;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q3[$];
    logic  m_rdy;

    mux_pipe #(.DATA_W(8), .NUM_IN(4), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_sel(in_sel), .in_en(in_en),
        .out_valid(vld0), .out_ready(out_ready), .out_data(data0), .out_src(src0), .out_err(err0)
    );

    mux_pipe #(.DATA_W(8), .NUM_IN(4), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_sel(in_sel), .in_en(in_en),
        .out_valid(vld1), .out_ready(out_ready), .out_data(data1), .out_src(src1), .out_err(err1)
    );

    mux_pipe #(.DATA_W(8), .NUM_IN(3), .MODE(0)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
        .in_data(in_data[23:0]), .in_sel(in_sel), .in_en(in_en[2:0]),
        .out_valid(vld3), .out_ready(out_ready), .out_data(data3), .out_src(src3), .out_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat for given inputs: lane scan written independently of the RTL.
    function automatic beat_t ref_beat(input int mode, input int nin, input logic [31:0] d,
                                       input logic [1:0] sel, input logic [3:0] en);
        beat_t b;
        int    i;
        b     = '0;
        b.err = 1'b1;
        if (mode == 0) begin
            if (int'(sel) < nin) begin
                b.err  = 1'b0;
                b.src  = sel;
                b.data = d[8*int'(sel) +: 8];
            end
        end else begin
            i = 0;
            while (i < nin && en[i] == 1'b0) i++;
            if (i < nin) begin
                b.err  = 1'b0;
                b.src  = 2'(i);
                b.data = d[8*i +: 8];
            end
        end
        return b;
    endfunction

    // One cycle against the reference queues: check outputs, then advance across an edge.
    task automatic step();
        beat_t e0, e1, e3;
        logic  acc, drn;
        chk("rdy0", rdy0, m_rdy);
        chk("rdy1", rdy1, m_rdy);
        chk("rdy3", rdy3, m_rdy);
        chk("vld0", vld0, q0.size() > 0);
        chk("vld1", vld1, q1.size() > 0);
        chk("vld3", vld3, q3.size() > 0);
        if (q0.size() > 0) chk("beat0", {data0, src0, err0}, q0[0]);
        if (q1.size() > 0) chk("beat1", {data1, src1, err1}, q1[0]);
        if (q3.size() > 0) chk("beat3", {data3, src3, err3}, q3[0]);
        acc = in_valid && m_rdy;
        drn = (q0.size() > 0) && out_ready;
        e0  = ref_beat(0, 4, in_data, in_sel, in_en);
        e1  = ref_beat(1, 4, in_data, in_sel, in_en);
        e3  = ref_beat(0, 3, in_data, in_sel, in_en);
        tick();
        if (drn) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            void'(q3.pop_front());
        end
        if (acc) begin
            q0.push_back(e0);
            q1.push_back(e1);
            q3.push_back(e3);
        end
        m_rdy = (q0.size() < 2);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_en     = '0;
        m_rdy     = 1'b0;

        // Reset state
        #3;
        chk("rst_vld", vld0, 1'b0);
        chk("rst_rdy", rdy0, 1'b0);
        chk("rst_data", data0, 8'h00);
        chk("rst_src", src0, 2'd0);
        chk("rst_err", err0, 1'b0);
        #9 rst = 1'b1;
        tick();
        chk("rel_rdy", rdy0, 1'b1);
        chk("rel_vld", vld0, 1'b0);

        // Binary select sel=2; priority en=1010 -> lane 1
        in_data   = 32'h44332211;
        in_sel    = 2'd2;
        in_en     = 4'b1010;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        // Next beat offered: must not disturb the buffered one
        in_sel  = 2'd3;
        in_en   = 4'b0000;
        chk("bin_vld", vld0, 1'b1);
        chk("bin_data", data0, 8'h33);
        chk("bin_src", src0, 2'd2);
        chk("bin_err", err0, 1'b0);
        chk("pri_src", src1, 2'd1);
        chk("pri_data", data1, 8'h22);
        chk("n3_data", data3, 8'h33);
        tick();
        in_valid = 1'b0;
        chk("oor_data", data3, 8'h00);
        chk("oor_src", src3, 2'd0);
        chk("oor_err", err3, 1'b1);
        chk("sel3_data", data0, 8'h44);
        chk("sel3_src", src0, 2'd3);
        chk("pri0_err", err1, 1'b1);
        chk("pri0_data", data1, 8'h00);
        tick();
        chk("drain_vld", vld0, 1'b0);

        // Backpressure: A=0x11, B=0x22, C=0x44
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        tick();
        chk("bp_rdyA", rdy0, 1'b1);
        in_sel = 2'd1;
        tick();
        chk("bp_rdyB", rdy0, 1'b0);
        chk("bp_holdA", data0, 8'h11);
        in_sel = 2'd3;
        tick();
        chk("bp_stallC", rdy0, 1'b0);
        chk("bp_holdA2", data0, 8'h11);
        chk("bp_vld", vld0, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("bp_outB", data0, 8'h22);
        chk("bp_rdy_again", rdy0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp_outC", data0, 8'h44);
        tick();
        chk("bp_nodup", vld0, 1'b0);

        // Reset with two beats buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        tick();
        in_sel = 2'd2;
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("mr_vld", vld0, 1'b0);
        chk("mr_data", data0, 8'h00);
        chk("mr_rdy", rdy0, 1'b0);
        chk("mr_src", src0, 2'd0);
        #2 rst = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("mr_rdy_rel", rdy0, 1'b1);
        chk("mr_nopulse", vld0, 1'b0);
        tick();
        chk("mr_nopulse2", vld0, 1'b0);

        // Random traffic against reference queues, with periodic both-high windows
        m_rdy = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            if ((c % 1000) < 150) begin
                in_valid  = 1'b1;
                out_ready = 1'b1;
            end else begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
            end
            in_data = $urandom;
            in_sel  = 2'($urandom_range(0, 3));
            in_en   = 4'($urandom_range(0, 15));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of each data input and of the output.
REQ-002 SHALL have parameter NUM_IN, default 4, legal range 2..16: number of data inputs.
REQ-003 SHALL have parameter MODE, default 0: 0 = binary select; 1 = priority enable, lowest asserted index wins.
REQ-004 SHALL derive localparam SEL_W = max(1, clog2(NUM_IN)).
REQ-005 SHALL have clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have rst, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have in_valid, input, 1: upstream beat valid.
REQ-008 SHALL have in_ready, output, 1: block can accept a beat.
REQ-009 SHALL have in_data, input, NUM_IN*DATA_W: packed inputs; input i occupies bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have in_sel, input, SEL_W: binary select, used when MODE=0.
REQ-011 SHALL have in_en, input, NUM_IN: per-input enables, used when MODE=1.
REQ-012 SHALL have out_valid, output, 1: output beat valid.
REQ-013 SHALL have out_ready, input, 1: downstream accepts the beat.
REQ-014 SHALL have out_data, output, DATA_W: selected data.
REQ-015 SHALL have out_src, output, SEL_W: index of the chosen input; 0 when out_err=1.
REQ-016 SHALL have out_err, output, 1: no valid selection; set when MODE=0 and in_sel>=NUM_IN, or when MODE=1 and in_en is all zero.

Function
REQ-017 SHALL accept a beat on a clock edge where in_valid && in_ready, and present it on a clock edge where out_valid && out_ready.
REQ-018 SHALL have a latency of 1 cycle: a beat accepted at edge N, with the buffer empty, SHALL be visible on the out_* ports after edge N.
REQ-019 SHALL compute selection combinationally at acceptance time; a later change to in_sel, in_en or in_data SHALL NOT alter a buffered beat.
REQ-020 SHALL drive out_data=0 and out_src=0 for a beat whose out_err=1.
REQ-021 SHALL, in MODE=1, select the lowest index i with in_en[i]=1; higher enabled indices SHALL be ignored.
REQ-022 SHALL hold up to two beats, in a main register and a skid register; in_ready SHALL be a registered signal equal to !skid_full.
REQ-023 SHALL implement a state machine with states EMPTY, ONE and TWO.
REQ-024 EMPTY: accept -> ONE.
REQ-025 ONE: accept only -> TWO, with the new beat in skid; drain only -> EMPTY; accept and drain together -> ONE, with the new beat in main.
REQ-026 TWO: in_ready=0; drain -> ONE, with skid moving to main.
REQ-027 SHALL preserve beat order strictly.
REQ-028 SHALL hold out_data, out_src and out_err stable while out_valid=1 and out_ready=0.
REQ-029 SHALL keep out_valid=1 continuously across back-to-back beats, giving full throughput of one beat per cycle when out_ready is held at 1.
REQ-030 SHALL ignore in_valid while in_ready=0; no beat is dropped or duplicated.

Reset
REQ-031 SHALL, while rst=0, force state EMPTY, out_valid=0, out_data=0, out_src=0, out_err=0, in_ready=0, and a cleared skid register.
REQ-032 SHALL assert in_ready on the first rising clk edge after rst deasserts.
REQ-033 SHALL discard buffered beats when reset is asserted mid-operation, with no output pulse on recovery.

Structure
REQ-034 SHALL place the state encodings (EMPTY, ONE, TWO) and the MODE constants in the shared defines file, and use `True_v/`False_v for flag comparisons.
REQ-035 SHALL place selection and error detection in a combinational sub-module mux_pipe_sel, parametrised by DATA_W, NUM_IN and MODE.
REQ-036 SHALL elaborate with no latches and produce no X on outputs after reset for any legal parameter set.

Verification
REQ-037 Reset: MODE=0, rst low mid-stream with two beats buffered -> out_valid=0, out_data=0; in_ready=1 one edge after release.
REQ-038 Binary select: NUM_IN=4, inputs 0x11/0x22/0x33/0x44, in_sel=2, out_ready=1 -> next cycle out_data=0x33, out_src=2, out_err=0.
REQ-039 Out of range: NUM_IN=3, in_sel=3 -> out_data=0, out_src=0, out_err=1.
REQ-040 Priority: MODE=1, in_en=4'b1010 -> out_src=1, out_data=input 1; in_en=0 -> out_err=1.
REQ-041 Backpressure: out_ready=0 with 3 beats A,B,C offered -> A,B accepted, in_ready=0, C stalled; raising out_ready delivers A,B,C in order with out_data held stable while stalled.
REQ-042 Throughput: random valid/ready over 10k cycles against a reference queue -> no loss, no duplication, order kept, one beat per cycle when both sides are held high.
